wakeup_tag_broadcaster: RTL and testbench
=========================================

Name: wakeup_tag_broadcaster

Overview:
- Transmit side of the issue-queue wakeup tag bus: turns arbiter grants into timed per-port tag broadcasts.
- The comparator side consumes these broadcasts against issue-queue source tags.
- Per-port latency model:
  - Single-cycle ALU ports: tag one cycle after grant.
  - Load port: fixed-depth delay pipeline with miss cancel.
  - Iterative mul/div port: counter FSM with busy back-pressure to the arbiter.
- Sits between the arbiter/issue select stage and the wakeup comparators.

Parameters:
ISSUE_NUM, 4, number of issue ports / tag buses
PRF_WIDTH, 6, physical register tag width
MD_PORT, 2, index of the iterative mul/div port
LD_PORT, 3, index of the load port
MD_LAT, 32, mul/div latency in cycles, grant to broadcast (>=3)
LD_LAT, 3, load latency in cycles, grant to broadcast (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
arbit_grant  input  ISSUE_NUM  per-port grant this cycle
arbit_prd  input  ISSUE_NUM*PRF_WIDTH  flat dest tags; port i at bits [i*PRF_WIDTH +: PRF_WIDTH]
arbit_prd_v  input  ISSUE_NUM  granted instruction writes a dest register
flush  input  1  pipeline flush; kills all in-flight broadcasts
ld_miss  input  1  load in final stage missed; suppress its broadcast
tag_bus_v  output  ISSUE_NUM  broadcast valid per port (registered)
tag_bus  output  ISSUE_NUM*PRF_WIDTH  flat broadcast tags (registered)
md_busy  output  1  mul/div unit occupied; arbiter must not grant MD_PORT
md_grant_err  output  1  sticky: MD_PORT granted while md_busy

Behaviour:
- Reset state: all outputs 0, load pipeline empty, MD FSM IDLE, counter 0.
- Broadcast qualifier `bcast_ok` = prd_v & (prd != 0). When tag_bus_v[i]=0, tag_bus[i] must be 0.
- Single-cycle ports (i != MD_PORT, i != LD_PORT):
  - Grant in cycle T with bcast_ok and !flush gives tag_bus_v[i]=1 and tag_bus[i]=prd in cycle T+1.
  - Otherwise the port outputs 0 in T+1.
- LD_PORT, shift pipeline of depth LD_LAT holding {valid, tag}:
  - A grant in T enters stage 0; the broadcast appears in T+LD_LAT.
  - ld_miss is sampled in cycle T+LD_LAT-1 (entry in last stage); if high, the output valid for T+LD_LAT is forced to 0.
  - flush clears every stage valid at the next edge; nothing already in the pipe broadcasts afterwards.
  - Back-to-back grants every cycle are supported.
- MD_PORT FSM with states IDLE and BUSY, and counter cnt of width clog2(MD_LAT):
  - IDLE, grant & !flush: go to BUSY, cnt=1, latch tag and bcast_ok. The unit is occupied even if !bcast_ok.
  - BUSY: cnt increments each cycle.
  - When cnt==MD_LAT-1: return to IDLE and present the latched tag (if bcast_ok) in the next cycle. That cycle is T+MD_LAT.
  - md_busy is high in cycles T+1 .. T+MD_LAT-1 and low in T+MD_LAT, so a back-to-back grant in T+MD_LAT is accepted.
  - Grant while md_busy: ignored (no state change) and md_grant_err set; it clears only on rst.
  - flush while BUSY: go to IDLE, cnt=0, no broadcast. md_busy is low from the next cycle.
  - flush in the same cycle as an IDLE grant: grant is dropped.
- flush precedence: flush overrides grants on all ports in the same cycle. The single-cycle outputs in T+1 are 0.
- Asynchronous rst mid-operation: immediate return to the reset state; in-flight tags are lost, with no broadcast after release.
- Ports are independent. The same tag on two ports in the same cycle is legal; both are broadcast.

Optional Feature:
- Macro: MD_EARLY_WAKE_EN.
- Defined: the MD broadcast fires in cycle T+MD_LAT-2 (two cycles before result writeback) so dependents issue in time to meet the bypass. md_busy timing is unchanged.
  - flush after the early broadcast has no effect on that broadcast.
  - Requires MD_LAT>=3.
- Undefined: broadcast in T+MD_LAT as specified above.

Test Plan:
1. Port 0 grant, prd=6'd13, prd_v=1 at T -> tag_bus_v[0]=1, tag 13 at T+1 only; grant with prd=0 -> no valid.
2. LD_PORT grants at T, T+1, T+2 with tags 5, 6, 7 and ld_miss high at T+3 -> broadcasts: 5 at T+3, nothing at T+4, 7 at T+5.
3. MD_PORT grant with tag 9 at T:
   - md_busy high T+1..T+31.
   - tag_bus_v[2]=1, tag 9 only at T+32.
   - Second grant with tag 10 at T+32 -> broadcast at T+64.
4. MD_PORT grant at T, second grant at T+5 -> ignored, md_grant_err=1, only one broadcast, at T+32.
5. MD grant at T, flush at T+10 -> md_busy low at T+11, no MD broadcast ever. LD entries in flight at T+10 are also never broadcast.
6. With MD_EARLY_WAKE_EN: MD grant tag 4 at T -> broadcast at T+30, md_busy still low first at T+32. rst pulse at T+15 -> no broadcast, all outputs 0.

Source files
------------

// File: rtl/wakeup_tag_broadcaster.sv
// Wakeup tag bus transmitter: turns per-port arbiter grants into registered tag broadcasts.
// Optional macro MD_EARLY_WAKE_EN moves the mul/div broadcast two cycles ahead of writeback.
module wakeup_tag_broadcaster #(
    parameter int ISSUE_NUM = 4,
    parameter int PRF_WIDTH = 6,
    parameter int MD_PORT   = 2,
    parameter int LD_PORT   = 3,
    parameter int MD_LAT    = 32,
    parameter int LD_LAT    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ISSUE_NUM-1:0]           arbit_grant,
    input  logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prd,
    input  logic [ISSUE_NUM-1:0]           arbit_prd_v,
    input  logic                           flush,
    input  logic                           ld_miss,
    output logic [ISSUE_NUM-1:0]           tag_bus_v,
    output logic [ISSUE_NUM*PRF_WIDTH-1:0] tag_bus,
    output logic                           md_busy,
    output logic                           md_grant_err
);

    localparam int CNT_W = $clog2(MD_LAT);

    // MD handshake: arbit_grant[MD_PORT] is accepted only while md_busy is low;
    // a grant seen while md_busy is high is dropped and raises sticky md_grant_err.
    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    md_state_t                       r_md_state;
    md_state_t                       w_md_state_nxt;
    logic [CNT_W-1:0]                r_md_cnt;
    logic [CNT_W-1:0]                w_md_cnt_nxt;
    logic [PRF_WIDTH-1:0]            r_md_tag;
    logic                            r_md_ok;
    logic                            r_md_grant_err;
    logic [ISSUE_NUM-1:0]            r_bus_v;
    logic [ISSUE_NUM*PRF_WIDTH-1:0]  r_bus;
    logic [ISSUE_NUM-1:0]            w_bus_v_nxt;
    logic [ISSUE_NUM*PRF_WIDTH-1:0]  w_bus_nxt;
    logic [ISSUE_NUM-1:0]            w_ok;
    logic                            w_md_grant;
    logic                            w_md_accept;
    logic                            w_md_done;
    logic                            w_md_fire;
    logic [PRF_WIDTH-1:0]            w_md_fire_tag;
    logic                            w_ld_in_v;
    logic                            w_ld_last_v;
    logic [PRF_WIDTH-1:0]            w_ld_last_tag;

    always_comb begin
        w_ok = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            w_ok[i] = arbit_prd_v[i] & (arbit_prd[i*PRF_WIDTH +: PRF_WIDTH] != '0);
        end
    end

    assign w_md_grant  = arbit_grant[MD_PORT];
    assign w_md_accept = (r_md_state == MD_IDLE) & w_md_grant & ~flush;
    assign w_md_done   = (r_md_state == MD_BUSY) & (r_md_cnt == CNT_W'(MD_LAT - 1));
    assign w_ld_in_v   = arbit_grant[LD_PORT] & w_ok[LD_PORT] & ~flush;

    // MD FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= '0;
        end else begin
            r_md_state <= w_md_state_nxt;
            r_md_cnt   <= w_md_cnt_nxt;
        end
    end

    // MD FSM: next state
    always_comb begin
        w_md_state_nxt = r_md_state;
        w_md_cnt_nxt   = r_md_cnt;
        case (r_md_state)
            MD_IDLE: begin
                if (w_md_accept) begin
                    w_md_state_nxt = MD_BUSY;
                    w_md_cnt_nxt   = CNT_W'(1);
                end
            end
            MD_BUSY: begin
                if (flush || w_md_done) begin
                    w_md_state_nxt = MD_IDLE;
                    w_md_cnt_nxt   = '0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt + 1'b1;
                end
            end
            default: begin
                w_md_state_nxt = MD_IDLE;
                w_md_cnt_nxt   = '0;
            end
        endcase
    end

    // MD FSM: outputs
    always_comb begin
        md_busy = (r_md_state == MD_BUSY);
`ifdef MD_EARLY_WAKE_EN
        if (MD_LAT == 3) begin
            w_md_fire     = w_md_accept & w_ok[MD_PORT];
            w_md_fire_tag = arbit_prd[MD_PORT*PRF_WIDTH +: PRF_WIDTH];
        end else begin
            w_md_fire     = (r_md_state == MD_BUSY) & (r_md_cnt == CNT_W'(MD_LAT - 3))
                            & r_md_ok & ~flush;
            w_md_fire_tag = r_md_tag;
        end
`else
        w_md_fire     = w_md_done & r_md_ok & ~flush;
        w_md_fire_tag = r_md_tag;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_tag       <= '0;
            r_md_ok        <= 1'b0;
            r_md_grant_err <= 1'b0;
        end else begin
            if (w_md_accept) begin
                r_md_tag <= arbit_prd[MD_PORT*PRF_WIDTH +: PRF_WIDTH];
                r_md_ok  <= w_ok[MD_PORT];
            end
            if (w_md_grant && (r_md_state == MD_BUSY)) begin
                r_md_grant_err <= 1'b1;
            end
        end
    end

    // Load delay line; the output register is its final stage.
    generate
        if (LD_LAT == 1) begin : g_ld_direct
            assign w_ld_last_v   = w_ld_in_v;
            assign w_ld_last_tag = arbit_prd[LD_PORT*PRF_WIDTH +: PRF_WIDTH];
        end else begin : g_ld_pipe
            logic [LD_LAT-2:0]    r_ld_v;
            logic [PRF_WIDTH-1:0] r_ld_tag [LD_LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ld_v <= '0;
                    for (int k = 0; k < LD_LAT - 1; k++) begin
                        r_ld_tag[k] <= '0;
                    end
                end else begin
                    r_ld_v[0]   <= w_ld_in_v;
                    r_ld_tag[0] <= arbit_prd[LD_PORT*PRF_WIDTH +: PRF_WIDTH];
                    for (int k = 1; k < LD_LAT - 1; k++) begin
                        r_ld_v[k]   <= r_ld_v[k-1] & ~flush;
                        r_ld_tag[k] <= r_ld_tag[k-1];
                    end
                end
            end

            assign w_ld_last_v   = r_ld_v[LD_LAT-2];
            assign w_ld_last_tag = r_ld_tag[LD_LAT-2];
        end
    endgenerate

    always_comb begin
        w_bus_v_nxt = '0;
        w_bus_nxt   = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (i == LD_PORT) begin
                w_bus_v_nxt[i] = w_ld_last_v & ~ld_miss & ~flush;
                if (w_bus_v_nxt[i]) w_bus_nxt[i*PRF_WIDTH +: PRF_WIDTH] = w_ld_last_tag;
            end else if (i == MD_PORT) begin
                w_bus_v_nxt[i] = w_md_fire;
                if (w_bus_v_nxt[i]) w_bus_nxt[i*PRF_WIDTH +: PRF_WIDTH] = w_md_fire_tag;
            end else begin
                w_bus_v_nxt[i] = arbit_grant[i] & w_ok[i] & ~flush;
                if (w_bus_v_nxt[i]) begin
                    w_bus_nxt[i*PRF_WIDTH +: PRF_WIDTH] = arbit_prd[i*PRF_WIDTH +: PRF_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_v <= '0;
            r_bus   <= '0;
        end else begin
            r_bus_v <= w_bus_v_nxt;
            r_bus   <= w_bus_nxt;
        end
    end

    assign tag_bus_v    = r_bus_v;
    assign tag_bus      = r_bus;
    assign md_grant_err = r_md_grant_err;

endmodule

// File: tb/tb_wakeup_tag_broadcaster.sv
// Directed bench for wakeup_tag_broadcaster: ALU, load, mul/div, flush and reset scenarios.
module tb_wakeup_tag_broadcaster;

    localparam int N  = 4;
    localparam int W  = 6;
`ifdef MD_EARLY_WAKE_EN
    localparam int MD_FIRE = 30;
`else
    localparam int MD_FIRE = 32;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   arbit_grant;
    logic [N*W-1:0] arbit_prd;
    logic [N-1:0]   arbit_prd_v;
    logic           flush;
    logic           ld_miss;
    logic [N-1:0]   tag_bus_v;
    logic [N*W-1:0] tag_bus;
    logic           md_busy;
    logic           md_grant_err;

    int n_tests = 0;
    int n_fail  = 0;

    wakeup_tag_broadcaster dut (
        .clk          (clk),
        .rst          (rst),
        .arbit_grant  (arbit_grant),
        .arbit_prd    (arbit_prd),
        .arbit_prd_v  (arbit_prd_v),
        .flush        (flush),
        .ld_miss      (ld_miss),
        .tag_bus_v    (tag_bus_v),
        .tag_bus      (tag_bus),
        .md_busy      (md_busy),
        .md_grant_err (md_grant_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge: outputs are settled, inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arbit_grant = '0;
        arbit_prd   = '0;
        arbit_prd_v = '0;
        flush       = 1'b0;
        ld_miss     = 1'b0;
    endtask

    task automatic drive_port(input int p, input logic [W-1:0] tag, input logic v);
        arbit_grant[p]       = 1'b1;
        arbit_prd[p*W +: W]  = tag;
        arbit_prd_v[p]       = v;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) step();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] port_tag(input int p);
        return tag_bus[p*W +: W];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        n_tests++;
        if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_bus: v=%b tags=%h, expected v=0000 tags=000000", tag_bus_v, tag_bus);
        end
        n_tests++;
        if (md_busy !== 1'b0 || md_grant_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_md: busy=%b err=%b, expected 0 0", md_busy, md_grant_err);
        end
        repeat (2) step();
        rst = 1'b0;
        step();
        n_tests++;
        if (tag_bus_v !== 4'b0000 || md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: v=%b busy=%b, expected 0000 0", tag_bus_v, md_busy);
        end
    endtask

    task automatic test_single_cycle();
        apply_reset();
        drive_port(0, 6'd13, 1'b1);
        step();
        clear_inputs();
        n_tests++;
        if (tag_bus_v !== 4'b0001 || port_tag(0) !== 6'd13) begin
            n_fail++;
            $display("FAIL alu_grant: v=%b tag0=%0d, expected v=0001 tag0=13", tag_bus_v, port_tag(0));
        end
        step();
        n_tests++;
        if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0) begin
            n_fail++;
            $display("FAIL alu_one_cycle: v=%b tags=%h, expected 0000 000000", tag_bus_v, tag_bus);
        end
        drive_port(0, 6'd0, 1'b1);
        drive_port(1, 6'd20, 1'b0);
        step();
        clear_inputs();
        n_tests++;
        if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0) begin
            n_fail++;
            $display("FAIL alu_no_bcast: v=%b tags=%h, expected 0000 000000", tag_bus_v, tag_bus);
        end
        drive_port(0, 6'd33, 1'b1);
        drive_port(1, 6'd33, 1'b1);
        step();
        clear_inputs();
        n_tests++;
        if (tag_bus_v !== 4'b0011 || port_tag(0) !== 6'd33 || port_tag(1) !== 6'd33) begin
            n_fail++;
            $display("FAIL alu_same_tag: v=%b t0=%0d t1=%0d, expected 0011 33 33",
                     tag_bus_v, port_tag(0), port_tag(1));
        end
        drive_port(1, 6'd44, 1'b1);
        flush = 1'b1;
        step();
        clear_inputs();
        n_tests++;
        if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0) begin
            n_fail++;
            $display("FAIL alu_flush: v=%b tags=%h, expected 0000 000000", tag_bus_v, tag_bus);
        end
    endtask

    task automatic test_load();
        logic [N-1:0]   exp_v  [1:6];
        logic [W-1:0]   exp_t3 [1:6];
        exp_v  = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
        exp_t3 = '{6'd0, 6'd0, 6'd5, 6'd0, 6'd7, 6'd0};
        apply_reset();
        drive_port(3, 6'd5, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            clear_inputs();
            if (k == 1) drive_port(3, 6'd6, 1'b1);
            if (k == 2) drive_port(3, 6'd7, 1'b1);
            if (k == 3) ld_miss = 1'b1;
            n_tests++;
            if (tag_bus_v !== exp_v[k] || port_tag(3) !== exp_t3[k]) begin
                n_fail++;
                $display("FAIL load_pipe T+%0d: v=%b tag3=%0d, expected v=%b tag3=%0d",
                         k, tag_bus_v, port_tag(3), exp_v[k], exp_t3[k]);
            end
        end
    endtask

    task automatic test_md_back_to_back();
        apply_reset();
        drive_port(2, 6'd9, 1'b1);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 1; k <= 32; k++) begin
                step();
                clear_inputs();
                if (rep == 0 && k == 32) drive_port(2, 6'd10, 1'b1);
                n_tests++;
                if (md_busy !== (k < 32)) begin
                    n_fail++;
                    $display("FAIL md_busy rep%0d T+%0d: busy=%b, expected %b", rep, k, md_busy, k < 32);
                end
                n_tests++;
                if (tag_bus_v[2] !== (k == MD_FIRE) ||
                    port_tag(2) !== ((k == MD_FIRE) ? ((rep == 0) ? 6'd9 : 6'd10) : 6'd0)) begin
                    n_fail++;
                    $display("FAIL md_bcast rep%0d T+%0d: v2=%b tag2=%0d, expected v2=%b",
                             rep, k, tag_bus_v[2], port_tag(2), k == MD_FIRE);
                end
            end
        end
        n_tests++;
        if (md_grant_err !== 1'b0) begin
            n_fail++;
            $display("FAIL md_err_clean: err=%b, expected 0", md_grant_err);
        end
    endtask

    task automatic test_md_grant_err();
        apply_reset();
        drive_port(2, 6'd11, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            step();
            clear_inputs();
            if (k == 5) drive_port(2, 6'd12, 1'b1);
            n_tests++;
            if (tag_bus_v[2] !== (k == MD_FIRE) ||
                port_tag(2) !== ((k == MD_FIRE) ? 6'd11 : 6'd0)) begin
                n_fail++;
                $display("FAIL md_err_bcast T+%0d: v2=%b tag2=%0d, expected v2=%b tag2=11",
                         k, tag_bus_v[2], port_tag(2), k == MD_FIRE);
            end
            if (k == 5 || k == 6 || k == 32) begin
                n_tests++;
                if (md_grant_err !== (k >= 6) || md_busy !== (k < 32)) begin
                    n_fail++;
                    $display("FAIL md_err T+%0d: err=%b busy=%b, expected err=%b busy=%b",
                             k, md_grant_err, md_busy, k >= 6, k < 32);
                end
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive_port(2, 6'd9, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            clear_inputs();
            if (k == 7)  drive_port(3, 6'd20, 1'b1);
            if (k == 8)  drive_port(3, 6'd21, 1'b1);
            if (k == 9)  drive_port(3, 6'd22, 1'b1);
            if (k == 10) begin
                drive_port(3, 6'd23, 1'b1);
                drive_port(0, 6'd24, 1'b1);
                flush = 1'b1;
            end
            n_tests++;
            if (md_busy !== (k <= 10)) begin
                n_fail++;
                $display("FAIL flush_busy T+%0d: busy=%b, expected %b", k, md_busy, k <= 10);
            end
            n_tests++;
            if (tag_bus_v !== ((k == 10) ? 4'b1000 : 4'b0000) ||
                port_tag(3) !== ((k == 10) ? 6'd20 : 6'd0)) begin
                n_fail++;
                $display("FAIL flush_bcast T+%0d: v=%b tag3=%0d, expected v=%b",
                         k, tag_bus_v, port_tag(3), (k == 10) ? 4'b1000 : 4'b0000);
            end
        end
    endtask

    task automatic test_rst_mid();
        apply_reset();
        drive_port(2, 6'd4, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step();
            clear_inputs();
            if (k == 14) drive_port(3, 6'd30, 1'b1);
            if (k == 15) begin
                rst = 1'b1;
                #1;
                n_tests++;
                if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0 || md_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_async: v=%b tags=%h busy=%b, expected 0000 000000 0",
                             tag_bus_v, tag_bus, md_busy);
                end
            end
            if (k == 16) rst = 1'b0;
            if (k > 15) begin
                n_tests++;
                if (tag_bus_v !== 4'b0000 || tag_bus !== 24'h0 || md_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_after T+%0d: v=%b tags=%h busy=%b, expected all 0",
                             k, tag_bus_v, tag_bus, md_busy);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_cycle();
        test_load();
        test_md_back_to_back();
        test_md_grant_err();
        test_flush();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
